// File: rtl/raster_pkg.sv
// Shared raster front-end types: vertex word layout and the vertex source arbiter state.
package raster_pkg;

  localparam int VTX_W         = 104;
  localparam int VERTS_PER_TRI = 3;

  // Field order matches the FIFO word, MSB first.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  z;
    logic [31:0] u;
    logic [31:0] v;
  } vertex_t;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_i, wrapping around.
module rr_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               valid_o
);

  always_comb begin
    int k;
    k           = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    // The last granted source is checked last, so it only wins when nobody else asks.
    for (int i = 1; i <= NUM_SRC; i++) begin
      k = (int'(last_i) + i) % NUM_SRC;
      if (!valid_o && req_i[k]) begin
        valid_o     = 1'b1;
        grant_o[k]  = 1'b1;
        grant_idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/vertex_src_arbiter.sv
// Triangle-atomic round-robin arbiter feeding one vertex FIFO from NUM_SRC producers.
// Handshake: a vertex moves when i_src_valid[k] & o_src_ready[k] at a rising edge; ready never looks at valid.
module vertex_src_arbiter #(
  parameter int NUM_SRC       = 2,
  parameter int VTX_W         = raster_pkg::VTX_W,
  parameter int VERTS_PER_TRI = raster_pkg::VERTS_PER_TRI,
  parameter int CNT_W         = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_SRC-1:0]         i_src_valid,
  input  logic [NUM_SRC*VTX_W-1:0]   i_src_data,
  output logic [NUM_SRC-1:0]         o_src_ready,
  input  logic [NUM_SRC-1:0]         i_src_enable,
  input  logic                       i_pause,
  input  logic                       i_fifo_afull,
  output logic                       o_fifo_wr,
  output logic [VTX_W-1:0]           o_fifo_data,
  output logic [$clog2(NUM_SRC)-1:0] o_grant_id,
  output logic                       o_busy,
  output logic                       o_tri_done,
  output logic [CNT_W-1:0]           o_tri_cnt
);

  import raster_pkg::*;

  localparam int GIDW   = $clog2(NUM_SRC);
  localparam int VCNT_W = (VERTS_PER_TRI > 1) ? $clog2(VERTS_PER_TRI) : 1;

  arb_state_t          state_q;
  logic [GIDW-1:0]     grant_q;
  logic [NUM_SRC-1:0]  grant_oh_q;
  logic [GIDW-1:0]     rr_ptr_q;
  logic [VCNT_W-1:0]   vcnt_q;
  logic                fifo_wr_q;
  logic [VTX_W-1:0]    fifo_data_q;
  logic                tri_done_q;
  logic [CNT_W-1:0]    tri_cnt_q;

  logic [NUM_SRC-1:0]  arb_req;
  logic [NUM_SRC-1:0]  arb_oh;
  logic [GIDW-1:0]     arb_idx;
  logic                arb_valid;

  logic                in_xfer;
  logic                sel_valid;
  logic [VTX_W-1:0]    sel_data;
  logic                xfer;
  logic                last_vtx;

  assign arb_req = i_src_valid & i_src_enable;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (GIDW)
  ) u_rr (
    .req_i       (arb_req),
    .last_i      (rr_ptr_q),
    .grant_o     (arb_oh),
    .grant_idx_o (arb_idx),
    .valid_o     (arb_valid)
  );

  assign in_xfer     = (state_q == XFER);
  assign o_src_ready = in_xfer ? (grant_oh_q & {NUM_SRC{!i_fifo_afull}}) : '0;
  assign sel_valid   = |(i_src_valid & grant_oh_q);
  assign sel_data    = i_src_data[grant_q*VTX_W +: VTX_W];
  assign xfer        = in_xfer && sel_valid && !i_fifo_afull;
  assign last_vtx    = (vcnt_q == VCNT_W'(VERTS_PER_TRI - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= GIDW'(NUM_SRC - 1);
      vcnt_q      <= '0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      tri_done_q  <= 1'b0;
      tri_cnt_q   <= '0;
    end else begin
      fifo_wr_q  <= 1'b0;
      tri_done_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (!i_pause && arb_valid) begin
            grant_q    <= arb_idx;
            grant_oh_q <= arb_oh;
            rr_ptr_q   <= arb_idx;
            state_q    <= XFER;
          end
        end
        XFER: begin
          // Enable and pause are deliberately ignored here: the triangle always finishes.
          if (xfer) begin
            fifo_wr_q   <= 1'b1;
            fifo_data_q <= sel_data;
            if (last_vtx) begin
              vcnt_q     <= '0;
              tri_done_q <= 1'b1;
              tri_cnt_q  <= tri_cnt_q + CNT_W'(1);
              state_q    <= ARB;
            end else begin
              vcnt_q <= vcnt_q + VCNT_W'(1);
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign o_fifo_wr   = fifo_wr_q;
  assign o_fifo_data = fifo_data_q;
  assign o_grant_id  = grant_q;
  assign o_busy      = in_xfer;
  assign o_tri_done  = tri_done_q;
  assign o_tri_cnt   = tri_cnt_q;

endmodule

// File: doc/vertex_src_arbiter.md
Name: vertex_src_arbiter

Overview:
- Shares the single vertex FIFO in front of the triangle assembler between NUM_SRC vertex producers (mesh fetchers, debug/test-pattern generator).
- Grants are triangle-atomic: once a source is granted, exactly VERTS_PER_TRI vertices are taken from it before any other source is considered, so the assembler never sees interleaved triangles.
- Round-robin fairness across sources, a per-source enable mask, and a pause input for frame-boundary sequencing.

Parameters:
- NUM_SRC, 2, number of vertex producers (2..8)
- VTX_W, 104, vertex word width {x[15:0], y[15:0], z[7:0], u[31:0], v[31:0]}
- VERTS_PER_TRI, 3, vertices per atomic grant
- CNT_W, 32, width of the triangle counter

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_src_valid  in  NUM_SRC  per-source vertex valid
- i_src_data  in  NUM_SRC*VTX_W  per-source vertex; source k occupies bits [k*VTX_W +: VTX_W]
- o_src_ready  out  NUM_SRC  per-source accept (combinational)
- i_src_enable  in  NUM_SRC  arbitration mask; a disabled source is never newly granted
- i_pause  in  1  finish the current triangle, start no new grant
- i_fifo_afull  in  1  FIFO has fewer than 2 free entries
- o_fifo_wr  out  1  registered FIFO write strobe
- o_fifo_data  out  VTX_W  registered FIFO write data
- o_grant_id  out  $clog2(NUM_SRC)  currently or last granted source
- o_busy  out  1  high while in XFER
- o_tri_done  out  1  one-cycle pulse when the last vertex of a triangle is accepted
- o_tri_cnt  out  CNT_W  triangles forwarded since reset; wraps

Behaviour:
- Reset (async assert, sync release):
  - State goes to ARB.
  - o_fifo_wr=0, o_fifo_data=0, o_grant_id=0, o_busy=0, o_tri_done=0, o_tri_cnt=0.
  - Vertex counter=0 and rr pointer=NUM_SRC-1, so source 0 has first priority.
  - o_src_ready is 0 during reset.
- States:
  - ARB:
    - req = i_src_valid & i_src_enable.
    - If !i_pause and req!=0, select the first set bit searching from rr_ptr+1 with wrap-around. Register it into o_grant_id and rr_ptr, then go to XFER.
    - Otherwise stay in ARB.
    - Exactly one cycle minimum per arbitration decision.
  - XFER:
    - o_src_ready[g] = !i_fifo_afull; all other ready bits are 0.
    - Transfer occurs when valid&ready. On a transfer: the next edge gives o_fifo_wr=1 and o_fifo_data=vertex (latency 1), and the counter increments.
    - On the transfer where counter==VERTS_PER_TRI-1: counter resets to 0, o_tri_done pulses on the next cycle, o_tri_cnt increments (wrapping at 2^CNT_W), and the state returns to ARB.
- Backpressure: the afull threshold leaves 1 spare entry to cover the registered write latency. The arbiter never writes while the FIFO is full.
- Grant held mid-triangle:
  - If the granted source drops valid, the arbiter waits indefinitely in XFER; other sources are ignored.
  - i_src_enable or i_pause deasserting/asserting mid-triangle has no effect until the triangle completes.
- Only o_src_ready depends combinationally on inputs. There is no combinational valid-to-ready path; ready depends only on state, grant and i_fifo_afull.
- The same source may be re-granted back-to-back only when no other enabled source is requesting.
- Asserting reset mid-triangle drops the partial triangle; the FIFO and triangle assembler must be reset in the same domain event.
- o_busy=1 exactly while in XFER.

Decomposition:
- Package raster_pkg:
  - VTX_W and VERTS_PER_TRI constants.
  - Packed struct vertex_t {x, y, z, u, v} matching the 104-bit FIFO word.
  - arb_state_t enum {ARB, XFER}.
- Sub-module rr_arbiter(NUM_SRC): purely combinational. Takes req and last pointer; returns a one-hot grant and its index. Reused later for rasterizer tile scheduling.

Test Plan:
- Single source 0, three vertices with data 0x1..0x3, afull=0 → 3 writes of 0x1,0x2,0x3 on the cycles after each accept; one o_tri_done pulse; o_tri_cnt=1.
- Both sources continuously valid for 4 triangles → grant order 0,1,0,1; every FIFO triplet comes from a single source; o_tri_cnt=4.
- Source 1 granted, drops valid after vertex 1 for 10 cycles while source 0 is valid → no source-0 accepts; source 1 resumes and completes; source 0 is granted next.
- i_fifo_afull held high for 5 cycles mid-triangle → o_src_ready=0 and no writes; the triangle completes after release with no lost or duplicated vertex.
- i_pause raised after vertex 2 → third vertex still accepted, then stays in ARB with o_busy=0 until pause drops; i_src_enable=2'b10 → source 0 never granted.
- i_rst_n pulled low after vertex 1 → outputs immediately 0; after release, source 0 has priority and o_tri_cnt=0.
